// File: rtl/flag_unit.sv
// Condition-flag register and branch-condition evaluator for the EX stage.
// Captures Z/V/N from committed ALU results and resolves ID branches, with an EX-to-ID flag bypass.
module flag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_ccc,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        br_taken,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic flag_z_q, flag_v_q, flag_n_q, halted_q;
  logic flag_z_d, flag_v_d, flag_n_d, halted_d;

  logic upd_zvn, upd_z;
  logic z_new, v_new, n_new;
  logic ex_live, commit;
  logic eff_z, eff_v, eff_n;
  logic cond;

  always_comb begin
    upd_zvn = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
    upd_z   = upd_zvn || (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
              (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
  end

  assign z_new = (alu_result == 16'h0000);
  assign n_new = alu_result[15];
  assign v_new = alu_ovfl;

  // ex_live drives the bypass and deliberately ignores stall so a held EX/ID pair stays consistent.
  assign ex_live = ex_valid & ~flush & ~halted_q;
  assign commit  = ex_live & ~stall;

  always_comb begin
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    flag_n_d = flag_n_q;
    halted_d = halted_q;
    if (commit) begin
      if (upd_z) begin
        flag_z_d = z_new;
      end
      if (upd_zvn) begin
        flag_v_d = v_new;
        flag_n_d = n_new;
      end
      if (ex_opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
      halted_q <= halted_d;
    end
  end

  assign eff_z = (ex_live & upd_z)   ? z_new : flag_z_q;
  assign eff_v = (ex_live & upd_zvn) ? v_new : flag_v_q;
  assign eff_n = (ex_live & upd_zvn) ? n_new : flag_n_q;

  always_comb begin
    cond = 1'b0;
    case (br_ccc)
      3'b000: cond = ~eff_z;
      3'b001: cond = eff_z;
      3'b010: cond = ~eff_z & ~eff_n;
      3'b011: cond = eff_n;
      3'b100: cond = eff_z | (~eff_z & ~eff_n);
      3'b101: cond = eff_n | eff_z;
      3'b110: cond = eff_v;
      default: cond = 1'b1;
    endcase
  end

  assign br_taken = br_valid & cond;
  assign flag_z   = flag_z_q;
  assign flag_v   = flag_v_q;
  assign flag_n   = flag_n_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against {flag_z, flag_v, flag_n, halted, br_taken}.
module tb_flag_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic        flag_z, flag_v, flag_n, br_taken, halted;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  flag_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_ccc(br_ccc), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .br_taken(br_taken), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // exp packs {z, v, n, halted, br_taken}
  task automatic step(input string name, input logic r, input logic v, input logic [3:0] op,
                      input logic [15:0] res, input logic ovf, input logic st, input logic fl,
                      input logic bv, input logic [2:0] ccc, input logic [4:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; ex_opcode = op; alu_result = res; alu_ovfl = ovf;
    stall = st; flush = fl; br_valid = bv; br_ccc = ccc;
    e.cyc = cyc; e.name = name; e.exp = exp;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        act = {flag_z, flag_v, flag_n, halted, br_taken};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got zvn_h_bt=%b required %b", e.name, act, e.exp);
        end else begin
          $display("ok   %s: zvn_h_bt=%b", e.name, act);
        end
      end
    end
  end

  initial begin : stim
    checks = 0; errors = 0;
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = 4'h0; alu_result = 16'h0; alu_ovfl = 1'b0;
    stall = 1'b0; flush = 1'b0; br_valid = 1'b0; br_ccc = 3'b000;
    repeat (2) @(posedge clk);

    //    name             rst vld op    result    ovf st fl bv ccc     zvnhb
    step("reset_state",    0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 5'b00000);
    step("reset_add_eq",   0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b00001);
    step("add_zero_eq",    0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b10001);
    step("sat_add_ov_byp", 0, 1, 4'h0, 16'h8000, 1, 0, 0, 1, 3'd6, 5'b10001);
    step("xor_zero_le",    0, 1, 4'h2, 16'h0000, 0, 0, 0, 1, 3'd5, 5'b01101);
    step("xor_f0_ne",      0, 1, 4'h2, 16'h00F0, 0, 0, 0, 1, 3'd0, 5'b11101);
    step("red_no_update",  0, 1, 4'h3, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b01100);
    step("hold_lt",        0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd3, 5'b01101);
    step("sub_flush_ne",   0, 1, 4'h1, 16'h0000, 0, 0, 1, 1, 3'd0, 5'b01101);
    step("after_flush",    0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 5'b01101);
    step("sub_bypass_ne",  0, 1, 4'h1, 16'h0000, 0, 0, 0, 1, 3'd0, 5'b01100);
    step("sub_commit_ne",  0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 5'b10000);
    step("sat_neg_gt_byp", 0, 1, 4'h0, 16'h8000, 1, 0, 0, 1, 3'd2, 5'b10000);
    step("sat_neg_ov",     0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd6, 5'b01101);
    step("sat_neg_le",     0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd5, 5'b01101);
    step("sat_neg_ge",     0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd4, 5'b01100);
    step("sat_pos_ge_byp", 0, 1, 4'h0, 16'h7FFF, 1, 0, 0, 1, 3'd4, 5'b01101);
    step("sat_pos_lt",     0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd3, 5'b01000);
    for (int i = 0; i < 3; i++)
      step("stall_add_eq", 0, 1, 4'h0, 16'h0000, 0, 1, 0, 1, 3'd1, 5'b01001);
    step("stall_release",  0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b01001);
    step("br_invalid",     0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd7, 5'b10000);
    step("br_always",      0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd7, 5'b10001);
    step("stall_flush_lt", 0, 1, 4'h0, 16'h8000, 1, 1, 1, 1, 3'd3, 5'b10000);
    step("after_st_fl",    0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd3, 5'b10000);
    step("hlt_stalled",    0, 1, 4'hF, 16'h0000, 0, 1, 0, 0, 3'd0, 5'b10000);
    step("hlt_commit",     0, 1, 4'hF, 16'h0000, 0, 0, 0, 0, 3'd0, 5'b10000);
    step("halted_add_lt",  0, 1, 4'h0, 16'h8000, 1, 0, 0, 1, 3'd3, 5'b10010);
    step("halted_hold",    0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd3, 5'b10010);
    step("rst_assert",     1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 5'b10010);
    step("after_rst",      0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 5'b00000);
    step("rst_midstream",  1, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'd0, 5'b00000);
    step("after_midstrm",  0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 5'b00000);
    step("sra_z_only_lt",  0, 1, 4'h5, 16'h8000, 1, 0, 0, 1, 3'd3, 5'b00000);
    step("sra_z_only_ov",  0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd6, 5'b00000);
    step("paddsb_no_upd",  0, 1, 4'h7, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b00000);
    step("paddsb_after",   0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 5'b00000);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
